// File: rtl/xbtn_debounce_pkg.sv
// xbtn_debounce_pkg: shared register map and constants for the button
// conditioning block. Optional feature macro: BTN_AUTOREPEAT_EN.
package xbtn_debounce_pkg;

    // Register offsets inside the block's decoder slot
    localparam logic        BTN_LEVEL_ADDR = 1'b0;
    localparam logic        BTN_PRESS_ADDR = 1'b1;

    // Base address of the block's slot in the picoVersat address map
    localparam logic [31:0] BTN_BASE_ADDR  = 32'h0000_0120;

    // Width of the per-button auto-repeat timer
    localparam int          REP_TMR_W      = 25;

    typedef enum logic {
        REG_LEVEL = BTN_LEVEL_ADDR,
        REG_PRESS = BTN_PRESS_ADDR
    } btn_reg_e;

endpackage

// File: rtl/xbtn_debounce_if.sv
// xbtn_debounce_if: register bus between the address decoder and the
// button block. Optional feature macro: BTN_AUTOREPEAT_EN (no effect here).
interface xbtn_debounce_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic              we;
    logic              addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output sel, we, addr, data_in, input data_out);
    modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xbtn_db_cell.sv
// xbtn_db_cell: one button's synchroniser, debounce counter, stable level
// and rising-edge pulse. With BTN_AUTOREPEAT_EN defined, a hold timer adds
// repeat pulses while the button stays pressed.
module xbtn_db_cell
    import xbtn_debounce_pkg::*;
#(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
`ifdef BTN_AUTOREPEAT_EN
    , parameter int REP_DELAY  = 25000000
    , parameter int REP_PERIOD = 5000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_stable,
    output logic o_pulse
);

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_accept;

    assign w_differ = r_sync_p1 ^ r_stable;
    assign w_accept = w_differ && (r_cnt == CNT_W'(DB_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous board input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= i_btn;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differ) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_stable <= r_sync_p1;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Rising edge of the stable level, registered one cycle after it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_d <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
        end
    end

    assign o_stable = r_stable;

`ifdef BTN_AUTOREPEAT_EN
    logic [REP_TMR_W-1:0] r_tmr;
    logic                 r_rep;
    logic                 w_rep_fire;

    // Timer reads 1 in the press-pulse cycle, so reaching REP_DELAY lands
    // the first repeat REP_DELAY cycles after it; reloading lands later
    // repeats every REP_PERIOD cycles.
    assign w_rep_fire = r_stable && (r_tmr == REP_TMR_W'(REP_DELAY));

    // Hold timer and registered repeat pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
            r_rep <= 1'b0;
        end else begin
            r_rep <= w_rep_fire;
            if (!r_stable) begin
                r_tmr <= '0;
            end else if (w_rep_fire) begin
                r_tmr <= REP_TMR_W'(REP_DELAY - REP_PERIOD + 1);
            end else begin
                r_tmr <= r_tmr + REP_TMR_W'(1);
            end
        end
    end

    assign o_pulse = r_rise | r_rep;
`else
    assign o_pulse = r_rise;
`endif

endmodule

// File: rtl/xbtn_debounce.sv
// xbtn_debounce: N_BTN debounced buttons with sticky write-1-to-clear press
// flags and an interrupt, read through a two-register bus slot.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat press pulses).
module xbtn_debounce
    import xbtn_debounce_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20,
    parameter int DATA_W    = 32
`ifdef BTN_AUTOREPEAT_EN
    , parameter int REP_DELAY  = 25000000
    , parameter int REP_PERIOD = 5000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button_in,
    xbtn_debounce_if.slave   bus,
    output logic [N_BTN-1:0] press_pulse,
    output logic             irq
);

    logic [N_BTN-1:0] w_stable;
    logic [N_BTN-1:0] w_pulse;
    logic [N_BTN-1:0] w_clr;
    logic [N_BTN-1:0] w_press_nxt;
    logic [N_BTN-1:0] r_press;
    logic             r_irq;
    btn_reg_e         w_reg;
    logic             w_unused_din;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_cell
        xbtn_db_cell #(
            .DB_CYCLES  (DB_CYCLES),
            .CNT_W      (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
            , .REP_DELAY  (REP_DELAY)
            , .REP_PERIOD (REP_PERIOD)
`endif
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_btn    (button_in[gi]),
            .o_stable (w_stable[gi]),
            .o_pulse  (w_pulse[gi])
        );
    end

    assign w_reg        = btn_reg_e'(bus.addr);
    assign w_clr        = (bus.sel && bus.we && (w_reg == REG_PRESS)) ?
                          bus.data_in[N_BTN-1:0] : '0;
    // New pulses are OR-ed in after the clear so a coincident set wins
    assign w_press_nxt  = (r_press & ~w_clr) | w_pulse;
    assign w_unused_din = ^bus.data_in;

    // Sticky press flags and interrupt, updated in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_press <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_press <= w_press_nxt;
            r_irq   <= |w_press_nxt;
        end
    end

    // Read mux: zero-extended register, zero when the slot is not selected
    always_comb begin
        bus.data_out = '0;
        if (bus.sel) begin
            if (w_reg == REG_PRESS) begin
                bus.data_out = DATA_W'(r_press);
            end else begin
                bus.data_out = DATA_W'(w_stable);
            end
        end
    end

    assign press_pulse = w_pulse;
    assign irq         = r_irq;

endmodule

// File: doc/xbtn_debounce.md
Name: xbtn_debounce

Overview:
Conditioning stage directly upstream of the button read port on the picoVersat data bus. It takes N_BTN raw asynchronous push-button inputs from the board and synchronises and debounces each one. It also detects rising edges and holds sticky press flags for the controller to read and clear through the address decoder. The software then sees clean levels plus latched "was pressed" events, so it cannot miss short presses between polls.

Parameters:
N_BTN, 4, number of buttons (1..16)
DB_CYCLES, 500000, stable-sample count required to accept a new level (10 ms at 50 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
DATA_W, 32, data bus width (`DATA_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
button_in  in  N_BTN  raw board buttons, asynchronous, active-high
sel  in  1  block selected by address decoder
we  in  1  write strobe (qualified by sel)
addr  in  1  register select: 0 = LEVEL, 1 = PRESS
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data, combinational from registers, valid whenever sel=1 (zero when sel=0)
press_pulse  out  N_BTN  one-cycle pulse per accepted rising edge
irq  out  1  OR of all sticky press flags

Behaviour:
- Reset (rst=0, asynchronous): sync flops, stable levels, counters, sticky flags and repeat timers all 0. Outputs press_pulse=0, irq=0, data_out=0.
- Synchroniser: 2 flops per button. Sample s[i] is the second flop.
- Debounce, per button:
  - When s[i]==stable[i]: cnt <= 0.
  - When they differ: cnt increments.
  - When cnt==DB_CYCLES-1 and they still differ: stable[i] <= s[i] and cnt <= 0.
  - Any glitch shorter than DB_CYCLES cycles is rejected. The counter restarts on each bounce.
- Latency: a raw edge settled at cycle 0 reaches stable after exactly 2+DB_CYCLES cycles.
- press_pulse[i]: high for one cycle, the cycle after stable[i] goes 0->1. A release produces no pulse.
- Sticky PRESS[i]: set by press_pulse[i]. It is cleared by a write with sel=1, we=1, addr=1 and data_in[i]=1 (write-1-to-clear). Bits written 0 are unaffected. If a set and a clear hit the same cycle, set wins.
- Write to addr=0 is ignored.
- Read map: addr 0 returns {zeros, stable[N_BTN-1:0]}. addr 1 returns {zeros, PRESS[N_BTN-1:0]}. Upper bits are always 0.
- irq = |PRESS, registered together with PRESS (no extra cycle).
- Reset mid-debounce discards any partial count. A button held through reset release is re-accepted DB_CYCLES+2 cycles later and produces a pulse.
- Buttons are fully independent. Simultaneous edges on several buttons yield simultaneous pulses.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: extra parameters REP_DELAY (default 25000000) and REP_PERIOD (default 5000000), with a 25-bit timer per button.
  - While stable[i]=1, the timer counts.
  - The first repeat pulse fires REP_DELAY cycles after the initial press pulse. Further pulses fire every REP_PERIOD cycles.
  - Each repeat pulse sets PRESS[i].
  - The timer clears when stable[i]=0.
- Undefined: there are no timers, and exactly one pulse per press.

Decomposition:
- Add to xdefs.vh: BTN_LEVEL_ADDR (0), BTN_PRESS_ADDR (1), and the top-level base address for the block's decoder slot.
- Sub-module xbtn_db_cell: one button's sync, counter, stable flop and edge detector (plus the repeat timer under the macro). xbtn_debounce instantiates it N_BTN times via generate.
- The top holds the sticky flags and the bus interface.

Test Plan (DB_CYCLES=8, REP_DELAY=40, REP_PERIOD=10 in sim):
1. Reset hold: raw=4'hF during rst=0 -> data_out=0, irq=0. After release, stable=4'hF at cycle 10 with press_pulse=4'hF for one cycle at cycle 11; PRESS=4'hF.
2. Bounce: button 0 toggles every 3 cycles for 30 cycles, then holds 1 -> LEVEL[0] rises exactly 10 cycles after the last toggle, with a single press_pulse[0].
3. Glitch: button 2 high for 7 cycles -> LEVEL and PRESS unchanged, no pulse.
4. W1C: PRESS=4'b1011, write addr=1 data=4'b0001 -> PRESS=4'b1010. Write coincident with a new press on bit 0 -> bit 0 stays 1.
5. Read map: addr 0 -> stable levels only, upper 28 bits zero. Write to addr 0 -> no state change.
6. BTN_AUTOREPEAT_EN: hold button 1 for 100 cycles after acceptance -> pulses at +0, +40, +50, +60, +70, +80, +90. Undefined: only the +0 pulse.
